// File: rtl/mac_seq.sv
`default_nettype none
// ============================================================================
// mac_seq : dot-product sequencer; clears one MAC, streams operand pairs,
//           waits out the MAC latency and returns the accumulated result.
// Rev 1.0
// ============================================================================
module mac_seq #(
  parameter int LEN_W   = 16,
  parameter int MAC_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic [31:0]      in_weight,
  output logic             mac_rst_n,
  output logic [31:0]      mac_data_value,
  output logic [31:0]      mac_weight_value,
  output logic             mac_data_valid,
  output logic             mac_weight_valid,
  input  logic [31:0]      mac_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_data
);

  localparam int DRAIN_W = (MAC_LAT < 1) ? 1 : $clog2(MAC_LAT + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CLEAR  = 3'd1;
  localparam logic [2:0] S_STREAM = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]         r_state;
  logic [2:0]         w_state_nxt;
  logic [LEN_W-1:0]   r_remain;
  logic [DRAIN_W-1:0] r_drain;
  logic               r_mac_rst_n;
  logic               r_mac_valid;
  logic [31:0]        r_mac_data;
  logic [31:0]        r_mac_weight;
  logic [31:0]        r_res_data;
  logic               w_beat;
  logic               w_last_beat;

  assign w_beat      = in_valid && (r_state == S_STREAM);
  assign w_last_beat = w_beat && (r_remain == LEN_W'(1));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (start) w_state_nxt = (len != '0) ? S_CLEAR : S_DONE;
      S_CLEAR:  w_state_nxt = S_STREAM;
      S_STREAM: if (w_last_beat) w_state_nxt = S_DRAIN;
      S_DRAIN:  if (r_drain == '0) w_state_nxt = S_DONE;
      S_DONE:   if (res_ready) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_remain     <= '0;
      r_drain      <= '0;
      r_mac_rst_n  <= 1'b0;
      r_mac_valid  <= 1'b0;
      r_mac_data   <= '0;
      r_mac_weight <= '0;
      r_res_data   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      // MAC clear is timed off the next state so it lands exactly in CLEAR
      r_mac_rst_n <= (w_state_nxt != S_CLEAR);
      r_mac_valid <= w_beat;
      if (w_beat) begin
        r_mac_data   <= in_data;
        r_mac_weight <= in_weight;
        r_remain     <= r_remain - LEN_W'(1);
      end
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (len != '0) r_remain   <= len;
            else           r_res_data <= '0;
          end
        end
        S_STREAM: begin
          if (w_last_beat) r_drain <= DRAIN_W'(MAC_LAT);
        end
        S_DRAIN: begin
          if (r_drain == '0) r_res_data <= mac_out;
          else               r_drain    <= r_drain - DRAIN_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign busy             = (r_state != S_IDLE);
  assign in_ready         = (r_state == S_STREAM);
  assign res_valid        = (r_state == S_DONE);
  assign res_data         = r_res_data;
  assign mac_rst_n        = r_mac_rst_n;
  assign mac_data_value   = r_mac_data;
  assign mac_weight_value = r_mac_weight;
  assign mac_data_valid   = r_mac_valid;
  assign mac_weight_valid = r_mac_valid;

endmodule
`default_nettype wire

// File: doc/mac_seq.md
# mac_seq

Dot-product sequencer for the `MAC` accumulator unit. It accepts a job of `len` element pairs, clears the MAC accumulator, and streams the data/weight pairs into it through a valid/ready handshake. It then waits out the MAC pipeline latency and returns the accumulated single-precision result through a valid/ready handshake. It sits between the tile scheduler, which issues jobs and streams operands, and one `MAC` instance; it is the only driver of that MAC.

## Interface

Parameters:
- `LEN_W`, 16: width of the job length field; maximum job is 2^LEN_W−1 pairs.
- `MAC_LAT`, 1: cycles from a pair being presented on the MAC inputs to `mac_out` reflecting it. Must be ≥1.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  job request; sampled only in IDLE.
- `len`  in  LEN_W  number of pairs; sampled with `start`.
- `busy`  out  1  high in every state except IDLE.
- `in_valid`  in  1  operand pair valid.
- `in_ready`  out  1  operand pair accepted when high with `in_valid`.
- `in_data`  in  32  IEEE-754 single data operand.
- `in_weight`  in  32  IEEE-754 single weight operand.
- `mac_rst_n`  out  1  drives MAC `rst_n` (accumulator clear), registered.
- `mac_data_value`, `mac_weight_value`  out  32  registered operands to MAC `data.value` / `weight.value`.
- `mac_data_valid`, `mac_weight_valid`  out  1  registered, always equal; drive MAC `.valid` fields.
- `mac_out`  in  32  MAC accumulator output.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  result consumed when high with `res_valid`.
- `res_data`  out  32  captured accumulator value.

## Operation

- States: IDLE, CLEAR, STREAM, DRAIN, DONE.
- IDLE: `in_ready`=0. `start`=1 and `len`≠0 → latch `len` into the remaining counter, go to CLEAR. `start`=1 and `len`=0 → `res_data`←0x00000000, go to DONE (no MAC clear).
- CLEAR: exactly 1 cycle with `mac_rst_n`=0, then STREAM.
- STREAM: `in_ready`=1. A beat is `in_valid && in_ready`.
  - Each beat registers `in_data`/`in_weight` onto the MAC value outputs with the valid outputs =1 on the next cycle.
  - A cycle with no beat drives the MAC valids to 0 on the next cycle; value outputs hold. The MAC must not accumulate when valid=0.
  - The remaining counter decrements per beat. The beat that brings it to 0 moves the FSM to DRAIN and loads the drain counter with `MAC_LAT`. `in_ready` is 0 from the next cycle.
- DRAIN: `in_ready`=0. The drain counter decrements each cycle. In the cycle it reads 0, `res_data`←`mac_out` and the FSM moves to DONE.
- DONE: `res_valid`=1 and `res_data` stable. On `res_ready`=1 → IDLE. `start` is ignored in every non-IDLE state.
- No arithmetic is performed here; operands and results pass bit-exact (NaN/Inf/denormal untouched).

## Timing

- Reset (async assert, synchronous release by clock edge) values:
  - FSM IDLE; `busy`=0, `in_ready`=0, `res_valid`=0, `res_data`=0.
  - `mac_rst_n`=0 while `rst_n`=0, then 1 from the first clock in IDLE.
  - MAC value outputs 0, MAC valids 0, counters 0.
- Reset mid-job: immediate return to IDLE; the partial job is discarded; `mac_rst_n` low clears the MAC.
- `start` at cycle T (len≠0): CLEAR at T+1 (`mac_rst_n`=0), STREAM at T+2 (`in_ready`=1 from T+2).
- Beat at cycle t → MAC valids=1 with those operands during t+1.
- Last beat at t_L: DRAIN during t_L+1…t_L+1+MAC_LAT. `res_valid`=1 from t_L+2+MAC_LAT.
- Zero-length job: `start` at T → `res_valid`=1 at T+1.
- Minimum job-to-job gap: DONE→IDLE takes 1 cycle; the next `start` is accepted in IDLE. `start` held high during DONE is not a new job until IDLE.
- `busy` is registered with the state: 1 from T+1 through the `res_valid`/`res_ready` handshake cycle.

## Test plan

- Single pair: `len`=1, (5.0, 5.0) = (0x40A00000, 0x40A00000), `res_ready`=1 → `res_data`=0x41C80000 (25.0), `res_valid` one cycle at t_L+3 (MAC_LAT=1).
- Three pairs with bubbles: `len`=3, (1,2),(3,4),(5,6), `in_valid` low for 2 cycles between beats → `res_data`=0x42300000 (44.0). MAC valids low in the bubble cycles; exactly 3 valid MAC cycles.
- Back-to-back jobs: 44.0 job, then `len`=1 (2.0, 3.0) → second result 0x40C00000 (6.0), proving CLEAR between jobs. `start` held during DONE is not double-accepted.
- Zero length: `start`, `len`=0 → `res_data`=0x00000000 at T+1. `mac_rst_n` never pulses and `in_ready` stays 0.
- Result backpressure: `res_ready`=0 for 10 cycles in DONE → `res_valid` and `res_data` held stable. `start` ignored; IDLE one cycle after `res_ready`=1.
- Reset mid-STREAM: assert `rst_n`=0 after 2 of 3 beats → all outputs at reset values asynchronously. A fresh `len`=1 (5.0, 5.0) job then yields 0x41C80000.
